// File: rtl/accel_pkg.sv
// Shared constants for the CPU accelerator-bus adapters: accel IDs,
// keyboard event-word layout and command bits.
package accel_pkg;
    localparam int ACCEL_ID_SWAP     = 0;
    localparam int ACCEL_ID_LINE     = 1;
    localparam int ACCEL_ID_FILL     = 2;
    localparam int ACCEL_ID_KEYBOARD = 3;

    localparam int ACCEL_DATA_W = 16;
    typedef logic [ACCEL_DATA_W-1:0] accel_word_t;

    localparam int EV_LEFT  = 8;
    localparam int EV_RIGHT = 9;
    localparam int EV_BKSP  = 10;
    localparam int EV_OVF   = 15;

    localparam int CMD_FLUSH   = 0;
    localparam int CMD_CLR_OVF = 1;
endpackage

// File: rtl/keyboard_accel_adapter_if.sv
// Accelerator-bus handshake between the CPU (master) and an accel responder (slave).
interface keyboard_accel_adapter_if;
    import accel_pkg::*;

    logic        accel_can_read;
    logic        accel_can_write;
    logic        accel_read_enable;
    accel_word_t accel_read_data;
    logic        accel_write_enable;
    accel_word_t accel_write_data;

    modport master (
        input  accel_can_read, accel_can_write, accel_read_data,
        output accel_read_enable, accel_write_enable, accel_write_data
    );

    modport slave (
        output accel_can_read, accel_can_write, accel_read_data,
        input  accel_read_enable, accel_write_enable, accel_write_data
    );
endinterface

// File: rtl/keyboard_event_fifo.sv
// Synchronous show-ahead FIFO with push/pop/flush; head word is visible
// combinationally whenever the FIFO is non-empty.
module keyboard_event_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q, cnt_d;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Caller guarantees push only when not full (or popping) and pop only when not empty.
    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/keyboard_accel_adapter.sv
// Accel-bus responder (id 3): packs keyboard strobes into event words, queues
// them, tracks overflow and decodes flush / clear-overflow commands.
module keyboard_accel_adapter
    import accel_pkg::*;
#(
    parameter int SYMBOL_WIDTH = 7,
    parameter int FIFO_DEPTH   = 8,
    localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    keyboard_left,
    input  logic                    keyboard_right,
    input  logic                    keyboard_backspace,
    input  logic [SYMBOL_WIDTH-1:0] keyboard_symbol,
    keyboard_accel_adapter_if.slave acc
);
    accel_word_t ev_word, head;
    logic        ev, flush, clr_ovf, full, empty;
    logic        push, pop, drop;
    logic        ovf_q, ovf_d;
    logic        can_write_q;

    assign ev = keyboard_left | keyboard_right | keyboard_backspace | (|keyboard_symbol);

    always_comb begin
        ev_word                     = '0;
        ev_word[SYMBOL_WIDTH-1:0]   = keyboard_symbol;
        ev_word[EV_LEFT]            = keyboard_left;
        ev_word[EV_RIGHT]           = keyboard_right;
        ev_word[EV_BKSP]            = keyboard_backspace;
    end

    assign flush   = acc.accel_write_enable & acc.accel_write_data[CMD_FLUSH];
    assign clr_ovf = acc.accel_write_enable & acc.accel_write_data[CMD_CLR_OVF];

    // Flush dominates: no pop, no push, and the event in that cycle is lost.
    assign pop  = acc.accel_read_enable & ~empty & ~flush;
    assign push = ev & (~full | pop) & ~flush;
    assign drop = ev & full & ~pop & ~flush;

    always_comb begin
        ovf_d = ovf_q;
        if (flush)                  ovf_d = 1'b0;
        else if (drop)              ovf_d = 1'b1;
        else if (pop || clr_ovf)    ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q       <= 1'b0;
            can_write_q <= 1'b0;
        end else begin
            ovf_q       <= ovf_d;
            can_write_q <= 1'b1;
        end
    end

    keyboard_event_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ACCEL_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (ev_word),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // The overflow flag only becomes visible riding on a real word.
    always_comb begin
        acc.accel_read_data = '0;
        if (!empty) begin
            acc.accel_read_data         = head;
            acc.accel_read_data[EV_OVF] = head[EV_OVF] | ovf_q;
        end
    end

    assign acc.accel_can_read  = ~empty;
    assign acc.accel_can_write = can_write_q;

    logic unused_wdata;
    assign unused_wdata = ^{acc.accel_write_data[ACCEL_DATA_W-1:2], FIFO_ADDR_WIDTH[0]};
endmodule

// File: tb/tb_keyboard_accel_adapter.sv
// Directed bench for keyboard_accel_adapter: queueing, packing, overflow,
// commands and asynchronous reset.
module tb_keyboard_accel_adapter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       kl, kr, kb;
    logic [6:0] ks;
    int         total = 0;
    int         bad   = 0;

    keyboard_accel_adapter_if acc();

    keyboard_accel_adapter #(.SYMBOL_WIDTH(7), .FIFO_DEPTH(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .keyboard_left      (kl),
        .keyboard_right     (kr),
        .keyboard_backspace (kb),
        .keyboard_symbol    (ks),
        .acc                (acc)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        kl = 0; kr = 0; kb = 0; ks = '0;
        acc.accel_read_enable  = 0;
        acc.accel_write_enable = 0;
        acc.accel_write_data   = '0;
    endtask

    task automatic do_pop;
        acc.accel_read_enable = 1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 0;
        kl = 0; kr = 0; kb = 0; ks = '0;
        acc.accel_read_enable = 0; acc.accel_write_enable = 0; acc.accel_write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (acc.accel_can_read !== 1'b0) begin bad++; $display("FAIL reset_can_read got=%b exp=0", acc.accel_can_read); end
        total++; if (acc.accel_can_write !== 1'b0) begin bad++; $display("FAIL reset_can_write got=%b exp=0", acc.accel_can_write); end
        total++; if (acc.accel_read_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", acc.accel_read_data); end
        rst_n = 1;
        tick();
        total++; if (acc.accel_can_write !== 1'b1) begin bad++; $display("FAIL post_reset_can_write got=%b exp=1", acc.accel_can_write); end
    endtask

    task automatic test_single_symbol;
        ks = 7'h41;
        tick();
        total++; if (acc.accel_can_read !== 1'b1) begin bad++; $display("FAIL sym_can_read got=%b exp=1", acc.accel_can_read); end
        total++; if (acc.accel_read_data !== 16'h0041) begin bad++; $display("FAIL sym_data got=%h exp=0041", acc.accel_read_data); end
        do_pop();
        total++; if (acc.accel_can_read !== 1'b0) begin bad++; $display("FAIL sym_after_pop got=%b exp=0", acc.accel_can_read); end
        total++; if (acc.accel_read_data !== 16'h0000) begin bad++; $display("FAIL sym_empty_data got=%h exp=0000", acc.accel_read_data); end
    endtask

    task automatic test_pack_order;
        kl = 1; kb = 1;
        tick();
        kr = 1;
        tick();
        total++; if (acc.accel_read_data !== 16'h0500) begin bad++; $display("FAIL pack_first got=%h exp=0500", acc.accel_read_data); end
        do_pop();
        total++; if (acc.accel_read_data !== 16'h0200) begin bad++; $display("FAIL pack_second got=%h exp=0200", acc.accel_read_data); end
        do_pop();
        total++; if (acc.accel_can_read !== 1'b0) begin bad++; $display("FAIL pack_drained got=%b exp=0", acc.accel_can_read); end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 9; i++) begin
            ks = 7'(i);
            tick();
        end
        total++; if (acc.accel_read_data !== 16'h8001) begin bad++; $display("FAIL ovf_first got=%h exp=8001", acc.accel_read_data); end
        do_pop();
        total++; if (acc.accel_read_data !== 16'h0002) begin bad++; $display("FAIL ovf_second got=%h exp=0002", acc.accel_read_data); end
        for (int i = 2; i <= 8; i++) begin
            total++;
            if (acc.accel_can_read !== 1'b1 || acc.accel_read_data !== 16'(i)) begin
                bad++; $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", i, acc.accel_can_read, acc.accel_read_data, 16'(i));
            end
            do_pop();
        end
        total++; if (acc.accel_can_read !== 1'b0) begin bad++; $display("FAIL ovf_sym9_seen got=%b/%h exp=0", acc.accel_can_read, acc.accel_read_data); end
    endtask

    task automatic test_full_push_pop;
        for (int i = 1; i <= 8; i++) begin
            ks = 7'(16 + i);
            tick();
        end
        total++; if (acc.accel_read_data !== 16'h0011) begin bad++; $display("FAIL full_head got=%h exp=0011", acc.accel_read_data); end
        ks = 7'h05; acc.accel_read_enable = 1;
        tick();
        for (int i = 2; i <= 8; i++) begin
            total++;
            if (acc.accel_read_data !== 16'(16 + i)) begin
                bad++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, acc.accel_read_data, 16'(16 + i));
            end
            do_pop();
        end
        total++; if (acc.accel_can_read !== 1'b1 || acc.accel_read_data !== 16'h0005) begin
            bad++; $display("FAIL full_last got=%b/%h exp=1/0005", acc.accel_can_read, acc.accel_read_data);
        end
        do_pop();
        total++; if (acc.accel_can_read !== 1'b0) begin bad++; $display("FAIL full_count got=%b exp=0", acc.accel_can_read); end
    endtask

    task automatic test_empty_read;
        acc.accel_read_enable = 1;
        tick();
        total++; if (acc.accel_can_read !== 1'b0 || acc.accel_read_data !== 16'h0000) begin
            bad++; $display("FAIL empty_read got=%b/%h exp=0/0000", acc.accel_can_read, acc.accel_read_data);
        end
        ks = 7'h03; acc.accel_read_enable = 1;
        tick();
        total++; if (acc.accel_can_read !== 1'b1 || acc.accel_read_data !== 16'h0003) begin
            bad++; $display("FAIL empty_read_push got=%b/%h exp=1/0003", acc.accel_can_read, acc.accel_read_data);
        end
        do_pop();
    endtask

    task automatic test_clear_ovf;
        for (int i = 1; i <= 9; i++) begin
            ks = 7'(i);
            tick();
        end
        total++; if (acc.accel_read_data !== 16'h8001) begin bad++; $display("FAIL clr_pre got=%h exp=8001", acc.accel_read_data); end
        acc.accel_write_enable = 1; acc.accel_write_data = 16'h0002;
        tick();
        total++; if (acc.accel_can_read !== 1'b1 || acc.accel_read_data !== 16'h0001) begin
            bad++; $display("FAIL clr_ovf got=%b/%h exp=1/0001", acc.accel_can_read, acc.accel_read_data);
        end
        acc.accel_write_enable = 1; acc.accel_write_data = 16'h0001;
        tick();
    endtask

    task automatic test_flush;
        for (int i = 1; i <= 3; i++) begin
            ks = 7'(i + 32);
            tick();
        end
        ks = 7'h22; acc.accel_write_enable = 1; acc.accel_write_data = 16'h0001;
        tick();
        total++; if (acc.accel_can_read !== 1'b0 || acc.accel_read_data !== 16'h0000) begin
            bad++; $display("FAIL flush got=%b/%h exp=0/0000", acc.accel_can_read, acc.accel_read_data);
        end
        tick();
        total++; if (acc.accel_can_read !== 1'b0) begin bad++; $display("FAIL flush_event_lost got=%b exp=0", acc.accel_can_read); end
    endtask

    task automatic test_async_reset;
        for (int i = 1; i <= 4; i++) begin
            ks = 7'(i + 48);
            tick();
        end
        total++; if (acc.accel_read_data !== 16'h0031) begin bad++; $display("FAIL rst_pre got=%h exp=0031", acc.accel_read_data); end
        #2 rst_n = 0;
        #1;
        total++; if (acc.accel_can_read !== 1'b0 || acc.accel_read_data !== 16'h0000) begin
            bad++; $display("FAIL async_rst got=%b/%h exp=0/0000", acc.accel_can_read, acc.accel_read_data);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        tick();
        total++; if (acc.accel_can_write !== 1'b1 || acc.accel_can_read !== 1'b0) begin
            bad++; $display("FAIL rst_release got=%b/%b exp=1/0", acc.accel_can_write, acc.accel_can_read);
        end
    endtask

    initial begin
        test_reset();
        test_single_symbol();
        test_pack_order();
        test_overflow();
        test_full_push_pop();
        test_empty_read();
        test_clear_ovf();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
